// File: rtl/wshb_arb_pkg.sv
// wshb_arb_pkg: shared types, bus widths and round-robin helper for the two-master Wishbone arbiter.
package wshb_arb_pkg;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

    // With both requesting, the master that was not served last wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        return (req == 2'b11) ? ~last : req[1];
    endfunction

endpackage

// File: rtl/wshb_if.sv
// wshb_if: Wishbone bus bundle shared by the masters, the arbiter and the RAM controller.
interface wshb_if;
    import wshb_arb_pkg::*;

    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_ms;
    logic [DW-1:0] dat_sm;
    logic [SW-1:0] sel;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic          ack;
    logic          err;
    logic          rty;

    modport master(output cyc, stb, we, adr, dat_ms, sel, cti, bte, input ack, err, rty, dat_sm);
    modport slave(input cyc, stb, we, adr, dat_ms, sel, cti, bte, output ack, err, rty, dat_sm);

endinterface

// File: rtl/wshb_arb_mux.sv
// wshb_arb_mux: forwards the owning master to the shared slave port and gates the slave's returns.
module wshb_arb_mux
    import wshb_arb_pkg::*;
(
    input  arb_state_t state,
    wshb_if.slave      s0,
    wshb_if.slave      s1,
    wshb_if.master     m
);

    logic own0;
    logic own1;

    assign own0 = (state == OWN0);
    assign own1 = (state == OWN1);

    assign m.cyc    = own0 ? s0.cyc    : own1 ? s1.cyc    : 1'b0;
    assign m.stb    = own0 ? s0.stb    : own1 ? s1.stb    : 1'b0;
    assign m.we     = own0 ? s0.we     : own1 ? s1.we     : 1'b0;
    assign m.adr    = own0 ? s0.adr    : own1 ? s1.adr    : '0;
    assign m.dat_ms = own0 ? s0.dat_ms : own1 ? s1.dat_ms : '0;
    assign m.sel    = own0 ? s0.sel    : own1 ? s1.sel    : '0;
    assign m.cti    = own0 ? s0.cti    : own1 ? s1.cti    : '0;
    assign m.bte    = own0 ? s0.bte    : own1 ? s1.bte    : '0;

    // Returns only reach an owner that still holds cyc, so a handover-cycle ack is dropped.
    assign s0.ack = own0 & s0.cyc & m.ack;
    assign s0.err = own0 & s0.cyc & m.err;
    assign s0.rty = own0 & s0.cyc & m.rty;
    assign s1.ack = own1 & s1.cyc & m.ack;
    assign s1.err = own1 & s1.cyc & m.err;
    assign s1.rty = own1 & s1.cyc & m.rty;

    assign s0.dat_sm = m.dat_sm;
    assign s1.dat_sm = m.dat_sm;

endmodule

// File: rtl/wshb_arbiter_2m.sv
// wshb_arbiter_2m: round-robin, per-cycle arbitration of two Wishbone masters onto one SDRAM slave port,
// with debug grant state and per-master ack counters.
module wshb_arbiter_2m
    import wshb_arb_pkg::*;
#(
    parameter logic RESET_LAST = 1'b1,
    parameter int   CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    wshb_if.slave            wshb_ifs0,
    wshb_if.slave            wshb_ifs1,
    wshb_if.master           wshb_ifm,
    output logic [1:0]       grant,
    output logic [CNT_W-1:0] ack_cnt0,
    output logic [CNT_W-1:0] ack_cnt1
);

    arb_state_t state;
    logic       last;
    logic       pick;

    assign pick = rr_pick({wshb_ifs1.cyc, wshb_ifs0.cyc}, last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= RESET_LAST;
            grant    <= 2'b00;
            ack_cnt0 <= '0;
            ack_cnt1 <= '0;
        end else begin
            ack_cnt0 <= ack_cnt0 + CNT_W'(wshb_ifs0.ack);
            ack_cnt1 <= ack_cnt1 + CNT_W'(wshb_ifs1.ack);
            case (state)
                IDLE: if (wshb_ifs0.cyc | wshb_ifs1.cyc) begin
                    state <= pick ? OWN1 : OWN0;
                    grant <= pick ? 2'b10 : 2'b01;
                end
                OWN0: if (!wshb_ifs0.cyc) begin
                    last  <= 1'b0;
                    state <= wshb_ifs1.cyc ? OWN1 : IDLE;
                    grant <= wshb_ifs1.cyc ? 2'b10 : 2'b00;
                end
                OWN1: if (!wshb_ifs1.cyc) begin
                    last  <= 1'b1;
                    state <= wshb_ifs0.cyc ? OWN0 : IDLE;
                    grant <= wshb_ifs0.cyc ? 2'b01 : 2'b00;
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    wshb_arb_mux u_mux (
        .state(state),
        .s0   (wshb_ifs0),
        .s1   (wshb_ifs1),
        .m    (wshb_ifm)
    );

endmodule

// File: tb/tb_wshb_arbiter_2m.sv
// tb_wshb_arbiter_2m: directed bench with a per-master scoreboard checked at the shared slave port.
module tb_wshb_arbiter_2m;
    import wshb_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wshb_if ifs0 ();
    wshb_if ifs1 ();
    wshb_if ifm ();

    logic [1:0] grant;
    logic [3:0] ack_cnt0;
    logic [3:0] ack_cnt1;

    wshb_arbiter_2m #(.RESET_LAST(1'b1), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wshb_ifs0(ifs0),
        .wshb_ifs1(ifs1),
        .wshb_ifm (ifm),
        .grant    (grant),
        .ack_cnt0 (ack_cnt0),
        .ack_cnt1 (ack_cnt1)
    );

    logic        m_cyc[2];
    logic        m_stb[2];
    logic        m_we[2];
    logic [31:0] m_adr[2];
    logic [2:0]  m_cti[2];
    logic [1:0]  m_ack;
    logic [31:0] m_dat[2];

    assign ifs0.cyc = m_cyc[0];
    assign ifs0.stb = m_stb[0];
    assign ifs0.we = m_we[0];
    assign ifs0.adr = m_adr[0];
    assign ifs0.dat_ms = ~m_adr[0];
    assign ifs0.sel = 4'hF;
    assign ifs0.cti = m_cti[0];
    assign ifs0.bte = 2'b00;
    assign ifs1.cyc = m_cyc[1];
    assign ifs1.stb = m_stb[1];
    assign ifs1.we = m_we[1];
    assign ifs1.adr = m_adr[1];
    assign ifs1.dat_ms = ~m_adr[1];
    assign ifs1.sel = 4'hF;
    assign ifs1.cti = m_cti[1];
    assign ifs1.bte = 2'b00;
    assign m_ack[0] = ifs0.ack;
    assign m_ack[1] = ifs1.ack;
    assign m_dat[0] = ifs0.dat_sm;
    assign m_dat[1] = ifs1.dat_sm;

    // Slave model: one registered ack per strobe, read data derived from the address.
    logic s_ack;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_ack <= 1'b0;
        else s_ack <= ifm.cyc & ifm.stb & ~s_ack;
    end
    assign ifm.ack = s_ack;
    assign ifm.err = 1'b0;
    assign ifm.rty = 1'b0;
    assign ifm.dat_sm = {ifm.adr[15:0], ~ifm.adr[15:0]};

    int n_chk = 0;
    int n_fail = 0;
    logic abort = 1'b0;
    logic [32:0] exp0[$];
    logic [32:0] exp1[$];
    logic alt_en = 1'b0;
    logic seen_hi = 1'b0;
    int lo_len = 0;
    int gaps[$];
    logic [1:0] owners[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every slave-side ack must match the next expected beat of the current owner.
    always @(negedge clk) begin
        logic [32:0] e;
        logic has_exp;
        if (rst_n && ifm.cyc && ifm.stb && ifm.ack) begin
            has_exp = (grant == 2'b01 && exp0.size() > 0) || (grant == 2'b10 && exp1.size() > 0);
            chk("sb_owner_has_expected", 64'(has_exp), 64'd1);
            if (has_exp) begin
                e = (grant == 2'b01) ? exp0.pop_front() : exp1.pop_front();
                chk("sb_we_adr", 64'({ifm.we, ifm.adr}), 64'(e));
            end
            if (alt_en) owners.push_back(grant);
        end
        if (alt_en) begin
            if (ifm.cyc) begin
                if (seen_hi && lo_len > 0) gaps.push_back(lo_len);
                lo_len = 0;
                seen_hi = 1'b1;
            end else lo_len++;
        end
    end

    task automatic run(input int m, input logic [31:0] a, input int n, input logic we);
        int waited;
        logic [31:0] ea;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            if (m == 0) exp0.push_back({we, a + 32'(i)});
            else exp1.push_back({we, a + 32'(i)});
        end
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
        m_we[m] = we;
        m_adr[m] = a;
        m_cti[m] = (n > 1) ? 3'b010 : 3'b000;
        for (int i = 0; i < n && !abort; i++) begin
            if (n > 1 && i == n - 1) m_cti[m] = 3'b111;
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!m_ack[m] && !abort && waited < 200);
            if (abort) break;
            chk($sformatf("m%0d_ack_in_time", m), 64'(waited < 200), 64'd1);
            ea = a + 32'(i);
            if (!we) chk($sformatf("m%0d_rd_data", m), 64'(m_dat[m]), 64'({ea[15:0], ~ea[15:0]}));
            @(posedge clk);
            #1;
            if (i < n - 1) m_adr[m] = a + 32'(i + 1);
        end
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
        m_cti[m] = 3'b000;
    endtask

    // Request at cycle N must reach the slave port at N+1, not earlier.
    task automatic grant_chk(input string tag, input logic [1:0] g, input logic [31:0] a);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_grant_n"}, 64'(grant), 64'd0);
        chk({tag, "_cyc_n"}, 64'(ifm.cyc), 64'd0);
        @(negedge clk);
        chk({tag, "_grant_n1"}, 64'(grant), 64'(g));
        chk({tag, "_cyc_n1"}, 64'(ifm.cyc & ifm.stb), 64'd1);
        chk({tag, "_adr_n1"}, 64'(ifm.adr), 64'(a));
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 1'b0;
            m_stb[i] = 1'b0;
            m_we[i] = 1'b0;
            m_adr[i] = '0;
            m_cti[i] = '0;
        end
        // Reset state and first access
        repeat (2) @(negedge clk);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_cnt0", 64'(ack_cnt0), 64'd0);
        chk("rst_cnt1", 64'(ack_cnt1), 64'd0);
        chk("rst_slave_cyc", 64'(ifm.cyc | ifm.stb), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        fork
            run(0, 32'h100, 1, 1'b0);
            grant_chk("first", 2'b01, 32'h100);
        join
        @(negedge clk);
        chk("first_cnt0", 64'(ack_cnt0), 64'd1);
        chk("first_drop_slave_cyc", 64'(ifm.cyc), 64'd0);
        @(negedge clk);
        chk("first_idle_grant", 64'(grant), 64'd0);

        // Contention from IDLE: master 0 first after reset, master 1 after master 0 was served
        do_reset();
        fork
            run(0, 32'h200, 1, 1'b1);
            run(1, 32'h300, 1, 1'b1);
            grant_chk("cont1", 2'b01, 32'h200);
        join
        run(0, 32'h210, 1, 1'b1);
        repeat (2) @(negedge clk);
        fork
            run(0, 32'h220, 1, 1'b1);
            run(1, 32'h340, 1, 1'b1);
            grant_chk("cont2", 2'b10, 32'h340);
        join

        // Burst atomicity with a competing request mid-burst
        do_reset();
        fork
            run(1, 32'h400, 8, 1'b0);
            begin
                repeat (4) @(posedge clk);
                run(0, 32'h500, 1, 1'b1);
            end
            begin
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (m_cyc[1] && w < 200);
                chk("burst_end_in_time", 64'(w < 200), 64'd1);
                chk("burst_handover_grant_n", 64'(grant), 64'b10);
                chk("burst_handover_cyc_n", 64'(ifm.cyc), 64'd0);
                @(negedge clk);
                chk("burst_handover_grant_n1", 64'(grant), 64'b01);
                chk("burst_handover_adr_n1", 64'(ifm.adr), 64'h500);
            end
        join
        @(negedge clk);
        chk("burst_cnt1", 64'(ack_cnt1), 64'd8);
        chk("burst_cnt0", 64'(ack_cnt0), 64'd1);

        // Back-to-back alternation
        do_reset();
        gaps.delete();
        owners.delete();
        lo_len = 0;
        seen_hi = 1'b0;
        alt_en = 1'b1;
        fork
            for (int k = 0; k < 4; k++) run(0, 32'h1000 + 32'(k * 4), 1, 1'b1);
            for (int k = 0; k < 4; k++) run(1, 32'h2000 + 32'(k * 4), 1, 1'b1);
        join
        repeat (2) @(negedge clk);
        alt_en = 1'b0;
        chk("alt_gap_count", 64'(gaps.size()), 64'd7);
        foreach (gaps[k]) chk($sformatf("alt_gap%0d", k), 64'(gaps[k]), 64'd1);
        chk("alt_owner_count", 64'(owners.size()), 64'd8);
        foreach (owners[k]) chk($sformatf("alt_owner%0d", k), 64'(owners[k]), (k % 2) ? 64'b10 : 64'b01);
        chk("alt_cnt0", 64'(ack_cnt0), 64'd4);
        chk("alt_cnt1", 64'(ack_cnt1), 64'd4);

        // Asynchronous reset during beat 3 of a master 0 burst
        do_reset();
        fork
            run(0, 32'h3000, 8, 1'b0);
            begin
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (ack_cnt0 != 4'd2 && w < 200);
                chk("arst_reach_beat3", 64'(ack_cnt0), 64'd2);
                #2;
                rst_n = 1'b0;
                abort = 1'b1;
                #1;
                chk("arst_slave_cyc", 64'(ifm.cyc | ifm.stb), 64'd0);
                chk("arst_grant", 64'(grant), 64'd0);
                chk("arst_cnt0", 64'(ack_cnt0), 64'd0);
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                exp0.delete();
                abort = 1'b0;
            end
        join
        fork
            run(0, 32'h3100, 1, 1'b0);
            grant_chk("rearb", 2'b01, 32'h3100);
        join
        @(negedge clk);
        chk("rearb_cnt0", 64'(ack_cnt0), 64'd1);

        // Counter wrap at 4 bits
        do_reset();
        for (int k = 0; k < 17; k++) run(0, 32'h4000 + 32'(k * 4), 1, 1'b0);
        @(negedge clk);
        chk("wrap_cnt0", 64'(ack_cnt0), 64'd1);
        chk("wrap_cnt1", 64'(ack_cnt1), 64'd0);

        chk("sb_drained0", 64'(exp0.size()), 64'd0);
        chk("sb_drained1", 64'(exp1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wshb_arbiter_2m.md
# wshb_arbiter_2m

Two-master Wishbone arbiter sharing the single SDRAM slave port (the `wshb_if` slave backed by the RAM controller) between the video-input writer and the framebuffer reader feeding the display. It grants the bus per Wishbone cycle (`cyc` envelope) using round-robin between the two masters. It forwards the granted master's signals to the slave and returns `ack`/`dat_sm` only to the granted master. It also exports grant state and per-master ack counters for debug.

## Interface
- `RESET_LAST`, default 1: master index treated as "last served" at reset, so master 0 wins the first contended arbitration.
- `CNT_W`, default 16: width of the per-master ack counters.
- `clk`  in  1  system clock; same clock as all three `wshb_if` instances.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `wshb_ifs0`  `wshb_if.slave`  –  requester 0 (video-input writer).
- `wshb_ifs1`  `wshb_if.slave`  –  requester 1 (framebuffer reader).
- `wshb_ifm`  `wshb_if.master`  –  shared port to the RAM controller.
- `grant`  out  2  one-hot current owner; `2'b00` when idle.
- `ack_cnt0`, `ack_cnt1`  out  `CNT_W` each  acks delivered to each master; wrap modulo 2^`CNT_W`.

## Operation
- States: IDLE, OWN0, OWN1. `last` register holds the index of the most recently granted master.
- **IDLE**
  - Only `cyc0` high: go to OWN0.
  - Only `cyc1` high: go to OWN1.
  - Both high: grant the master ≠ `last`.
  - Neither high: stay in IDLE.
- **OWNx**
  - Stay while `cycx` = 1. Ownership is never revoked mid-cycle; a burst (`cti`/`bte`) completes atomically.
  - When `cycx` = 0: set `last` ← x.
    - If the other master's `cyc` is high, go directly to OWN(other).
    - Otherwise go to IDLE.
- **Slave-side outputs** (`cyc`, `stb`, `we`, `adr`, `dat_ms`, `sel`, `cti`, `bte`):
  - In OWNx: equal to master x's signals.
  - In IDLE: `cyc` = `stb` = 0; all other outputs 0.
- **Master-side returns**
  - `dat_sm` is broadcast to both masters.
  - `ack`/`err`/`rty` reach master x only when state = OWNx and `cycx` = 1. Otherwise they are 0.
- **Counters:** `ack_cntx` increments by 1 on each cycle where the ack delivered to master x is 1.
- **Ack in the handover cycle:** if a slave ack arrives in the same cycle the owner drops `cyc`, it is discarded and not counted. This situation is a slave protocol violation.

## Timing
- State, `last`, `grant` and the counters are registered. Slave-side outputs are combinational from the state and the owner's signals.
- **Grant latency:** `cyc` rises at cycle N with the arbiter in IDLE → state = OWNx at N+1 → slave sees `cyc`/`stb` at N+1. One cycle of added latency on the first access only. There is zero added latency within a cycle.
- **Handover:** owner drops `cyc` at cycle N → new owner's `cyc`/`stb` reach the slave at N+1. The slave sees `cyc` = 0 during cycle N.
- **Simultaneous requests in IDLE:** round-robin via `last`.
- **Handover choice:** with one other requester, it always goes to that other master. Fairness is therefore strict alternation under continuous load.
- **Reset** (asynchronous, any time, including mid-burst):
  - state = IDLE, `last` = `RESET_LAST`, `grant` = 0, counters = 0.
  - Slave `cyc`/`stb` = 0 immediately.
  - After release, arbitration restarts from IDLE. In-flight cycles are abandoned.

## Structure
- Shared package `wshb_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t`.
  - Helper function `rr_pick(req[1:0], last)` returning the winning index.
- Sub-module `wshb_arb_mux`: purely combinational forwarding of the owner's signals and gating of the returns, driven by the state. The arbiter top holds the FSM, `last` and the counters.

## Test plan
- **Reset/first access:** hold `rst_n` = 0, then release; master 0 `cyc`/`stb` at cycle 5 with `adr` = 0x100 → `grant` = 01 at cycle 6, slave `adr` = 0x100 at cycle 6; `ack_cnt0` = 1 after the ack.
- **Contention from IDLE:** `cyc0` and `cyc1` rise in the same cycle after reset → OWN0 first. On the next simultaneous contention after master 0 is served → OWN1.
- **Burst atomicity:** master 1 does an 8-beat incrementing read (`cti` = 010) while master 0 requests at beat 2 → all 8 acks go to master 1 and none to master 0; OWN0 begins the cycle after `cyc1` falls; `ack_cnt1` = 8.
- **Back-to-back alternation:** both masters issue 4 single writes continuously with `cyc` toggling → grants alternate 01/10. Slave `cyc` shows exactly one low cycle between owners. Both counters = 4.
- **Async reset mid-burst:** `rst_n` falls at beat 3 of a master-0 burst → slave `cyc` = 0 in the same cycle, `grant` = 0, counters = 0. Master 0 re-requests after release → granted one cycle later.
- **Counter wrap:** with `CNT_W` = 4, 17 acks to master 0 → `ack_cnt0` = 1.
